// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequencer for the iterative restoring 32-bit integer divider
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, dvd, dvs, mag1, mag2;
  logic [WIDTH:0] sh, diff;
  logic neg_q, neg_r, fire, zero;
  // operand magnitudes, one restoring step, and sign-corrected results
  always_comb begin
    fire = in_valid & in_ready & ~flush;
    zero = in_src2 == '0;
    mag1 = (in_signed & in_src1[WIDTH-1]) ? -in_src1 : in_src1;
    mag2 = (in_signed & in_src2[WIDTH-1]) ? -in_src2 : in_src2;
    sh = {rem, dvd[WIDTH-1]};
    diff = sh - {1'b0, dvs};
    out_quot = neg_q ? -dvd : dvd;
    out_rem = neg_r ? -rem : rem;
  end
  // control FSM plus datapath; dvd holds the dividend shifting out and the quotient shifting in
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      dvd <= '0;
      dvs <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (fire) begin
          neg_q <= ~zero & in_signed & (in_src1[WIDTH-1] ^ in_src2[WIDTH-1]);
          neg_r <= ~zero & in_signed & in_src1[WIDTH-1];
          dvd <= zero ? '1 : mag1;
          rem <= zero ? in_src1 : '0;
          dvs <= mag2;
          cnt <= '0;
          state <= zero ? DONE : CALC;
          in_ready <= 1'b0;
          out_valid <= zero;
          busy <= 1'b1;
        end
        CALC: begin
          rem <= diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], ~diff[WIDTH]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: random and directed checks of the divider sequencer against an arithmetic model
module tb_div_seq_ctrl;
  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, in_signed, out_valid, out_ready, busy;
  logic [31:0] in_src1, in_src2, out_quot, out_rem;
  int errs = 0;
  int checks = 0;

  div_seq_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .in_src1(in_src1), .in_src2(in_src2), .out_valid(out_valid),
    .out_ready(out_ready), .out_quot(out_quot), .out_rem(out_rem), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      lq = sa / sb;
      lr = sa % sb;
      q = lq[31:0];
      r = lr[31:0];
    end
  endtask

  task automatic start(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_signed = sgn;
    in_src1 = a;
    in_src2 = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_signed = 1'($urandom);
    in_src1 = $urandom;
    in_src2 = $urandom;
  endtask

  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int bp);
    logic [31:0] eq, er;
    int lat;
    model(sgn, a, b, eq, er);
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    start(sgn, a, b);
    lat = 1;
    if (b != 0) begin
      check("busy_calc", 32'(busy), 32'd1);
      check("in_ready_calc", 32'(in_ready), 32'd0);
    end
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), b == 0 ? 32'd1 : 32'd33);
    check("quot", out_quot, eq);
    check("rem", out_rem, er);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_quot", out_quot, eq);
      check("hold_rem", out_rem, er);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic watch_quiet(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_signed = 1'b0;
    in_src1 = '0;
    in_src2 = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_quot", out_quot, 32'd0);
    check("rst_rem", out_rem, 32'd0);
    do_op(1'b0, 32'd100, 32'd7, 0);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(1'b1, 32'h1234_5678, 32'd0, 2);
    do_op(1'b0, 32'h1234_5678, 32'd0, 0);
    do_op(1'b1, 32'hF000_0000, 32'd0, 0);
    do_op(1'b0, 32'd1000, 32'd33, 5);
    // flush in CALC after ten cycles: result never appears
    start(1'b0, 32'd500, 32'd5);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_busy", 32'(busy), 32'd0);
    watch_quiet("flush_no_valid", 40);
    // flush beats in_valid in IDLE
    @(negedge clk);
    in_valid = 1'b1;
    in_src1 = 32'd9;
    in_src2 = 32'd3;
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    check("flush_idle_busy", 32'(busy), 32'd0);
    watch_quiet("flush_idle_no_valid", 40);
    // flush beats out_ready in DONE (zero divisor reaches DONE immediately)
    start(1'b0, 32'd77, 32'd0);
    check("done_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b0;
    check("flush_done_valid", 32'(out_valid), 32'd0);
    check("flush_done_ready", 32'(in_ready), 32'd1);
    // reset a few cycles into a new op clears datapath too
    start(1'b1, 32'hFFFF_0000, 32'd7);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_in_ready", 32'(in_ready), 32'd1);
    check("rst2_quot", out_quot, 32'd0);
    check("rst2_rem", out_rem, 32'd0);
    watch_quiet("rst2_no_valid", 40);
    do_op(1'b0, 32'd9, 32'd3, 0);
    for (int k = 0; k < 40; k++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      do_op(1'($urandom), a, b, $urandom_range(0, 3));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
